fir_systolic_array: RTL and testbench

Parametrised transposed-form systolic FIR filter for fixed-point sample streams: TAPS processing elements, a broadcast input sample, and partial sums flowing PE to PE toward the output. It adds explicit command-driven modes to the systolic filter family (stop, coefficient load, run, bypass), valid-gated streaming with stall tolerance, and a scaled, saturated output. It sits in the filter library between a sample source with valid strobes and any downstream consumer.

---
 rtl/fir_systolic_array_if.sv | 30 +++
 rtl/fir_systolic_array.sv | 140 ++++++++++++++
 tb/tb_fir_systolic_array.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_systolic_array_if.sv
// Stream/command bundle for the systolic FIR filter.
// The master side feeds commands, coefficients and samples; the slave side returns results.
interface fir_systolic_array_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
) ();
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              coef_valid;
  logic [COEF_W-1:0] coef_in;
  logic              in_valid;
  logic [DATA_W-1:0] x_in;
  logic              out_valid;
  logic [OUT_W-1:0]  y_out;
  logic              sat_flag;
  logic [1:0]        mode;

  modport master (
    output cmd_valid, cmd, coef_valid, coef_in,
    output in_valid, x_in,
    input  out_valid, y_out, sat_flag, mode
  );

  modport slave (
    input  cmd_valid, cmd, coef_valid, coef_in,
    input  in_valid, x_in,
    output out_valid, y_out, sat_flag, mode
  );
endinterface

// File: rtl/fir_systolic_array.sv
// Transposed-form systolic FIR with stop/load/run/bypass modes.
// Partial sums flow toward tap 0; output is shifted and saturated.
module fir_systolic_array #(
  parameter int TAPS      = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic clk,
  input  logic rst,
  fir_systolic_array_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_BYP  = 2'd3
  } state_t;

  localparam int IW = $clog2(TAPS);

  localparam logic signed [ACC_W-1:0] YMAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] YMIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [COEF_W-1:0] h_q [TAPS];
  logic signed [COEF_W-1:0] h_d [TAPS];
  // p_q[i] holds partial sum p[i+1]
  logic signed [ACC_W-1:0] p_q [TAPS-1];
  logic signed [ACC_W-1:0] p_d [TAPS-1];
  logic [OUT_W-1:0] y_q, y_d;
  logic ov_q, ov_d;
  logic sat_q, sat_d;

  logic signed [ACC_W-1:0] xs;
  logic signed [ACC_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0] s, t;
  logic [OUT_W:0] cl;

  function automatic logic [OUT_W:0] clamp(
    input logic signed [ACC_W-1:0] v
  );
    if (v > YMAX) return {1'b1, YMAX[OUT_W-1:0]};
    else if (v < YMIN) return {1'b1, YMIN[OUT_W-1:0]};
    else return {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    xs = ACC_W'($signed(io.x_in));
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = ACC_W'(h_q[k]) * xs;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    h_d     = h_q;
    p_d     = p_q;
    y_d     = y_q;
    ov_d    = 1'b0;
    sat_d   = sat_q;
    s       = '0;
    t       = '0;
    cl      = '0;
    unique case (state_q)
      S_LOAD: begin
        if (io.coef_valid) begin
          h_d[idx_q] = $signed(io.coef_in);
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(TAPS-1)) state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (io.in_valid) begin
          s = prod[0] + p_q[0];
          for (int k = 1; k < TAPS-1; k++) begin
            p_d[k-1] = prod[k] + p_q[k];
          end
          p_d[TAPS-2] = prod[TAPS-1];
          t     = s >>> OUT_SHIFT;
          cl    = clamp(t);
          y_d   = cl[OUT_W-1:0];
          ov_d  = 1'b1;
          sat_d = sat_q | cl[OUT_W];
        end
      end
      S_BYP: begin
        if (io.in_valid) begin
          cl    = clamp(xs);
          y_d   = cl[OUT_W-1:0];
          ov_d  = 1'b1;
          sat_d = sat_q | cl[OUT_W];
        end
      end
      default: ;
    endcase
    // A command overrides any automatic transition in the same cycle
    if (io.cmd_valid) begin
      state_d = state_t'(io.cmd);
      if (state_t'(io.cmd) == S_LOAD) idx_d = '0;
      if (state_t'(io.cmd) == S_RUN) begin
        p_d   = '{default: '0};
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      h_q     <= '{default: '0};
      p_q     <= '{default: '0};
      y_q     <= '0;
      ov_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      h_q     <= h_d;
      p_q     <= p_d;
      y_q     <= y_d;
      ov_q    <= ov_d;
      sat_q   <= sat_d;
    end
  end

  assign io.out_valid = ov_q;
  assign io.y_out     = y_q;
  assign io.sat_flag  = sat_q;
  assign io.mode      = state_q;

endmodule

// File: tb/tb_fir_systolic_array.sv
// Bench for fir_systolic_array: directed vector table, corner sequences,
// and random traffic checked against a convolution model.
module tb_fir_systolic_array;

  localparam int TAPS = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int AW   = 40;
  localparam int OW   = 16;
  localparam int SH   = 0;

  logic clk;
  logic rst;

  fir_systolic_array_if #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW)) bus ();

  fir_systolic_array #(
    .TAPS(TAPS), .DATA_W(DW), .COEF_W(CW),
    .ACC_W(AW), .OUT_W(OW), .OUT_SHIFT(SH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int     m_state;
  int     m_idx;
  int     m_h [TAPS];
  int     m_hist [$];
  longint m_y;
  int     m_ov;
  int     m_sat;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat16(input longint v, output int hit);
    longint mx = (longint'(1) <<< (OW-1)) - 1;
    longint mn = -(longint'(1) <<< (OW-1));
    hit = 0;
    if (v > mx) begin hit = 1; return mx; end
    if (v < mn) begin hit = 1; return mn; end
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_idx = 0;
    foreach (m_h[k]) m_h[k] = 0;
    m_hist.delete();
    m_y = 0;
    m_ov = 0;
    m_sat = 0;
  endtask

  task automatic model_edge(input logic cv, input logic [1:0] c,
                            input logic kv, input logic [15:0] k,
                            input logic iv, input logic [15:0] x);
    longint s;
    int hit;
    m_ov = 0;
    case (m_state)
      1: if (kv) begin
        m_h[m_idx] = int'($signed(k));
        m_idx++;
        if (m_idx == TAPS) m_state = 0;
      end
      2: if (iv) begin
        m_hist.push_front(int'($signed(x)));
        if (m_hist.size() > TAPS) void'(m_hist.pop_back());
        s = 0;
        for (int j = 0; j < m_hist.size(); j++)
          s += longint'(m_h[j]) * longint'(m_hist[j]);
        m_y = sat16(s >>> SH, hit);
        m_ov = 1;
        if (hit != 0) m_sat = 1;
      end
      3: if (iv) begin
        m_y = sat16(longint'($signed(x)), hit);
        m_ov = 1;
        if (hit != 0) m_sat = 1;
      end
      default: ;
    endcase
    if (cv) begin
      m_state = int'(c);
      if (c == 2'd1) m_idx = 0;
      if (c == 2'd2) begin
        m_hist.delete();
        m_sat = 0;
      end
    end
  endtask

  task automatic drive(input logic cv, input logic [1:0] c,
                       input logic kv, input logic [15:0] k,
                       input logic iv, input logic [15:0] x);
    bus.cmd_valid  = cv;
    bus.cmd        = c;
    bus.coef_valid = kv;
    bus.coef_in    = k;
    bus.in_valid   = iv;
    bus.x_in       = x;
    @(posedge clk);
    model_edge(cv, c, kv, k, iv, x);
    #1;
    chk("m_ov", longint'(bus.out_valid), longint'(m_ov));
    chk("m_y", longint'($signed(bus.y_out)), m_y);
    chk("m_sat", longint'(bus.sat_flag), longint'(m_sat));
    chk("m_mode", longint'(bus.mode), longint'(m_state));
  endtask

  task automatic cmd_t(input logic [1:0] c);
    drive(1'b1, c, 1'b0, 16'd0, 1'b0, 16'd0);
  endtask
  task automatic coef_t(input int k);
    drive(1'b0, 2'd0, 1'b1, 16'(k), 1'b0, 16'd0);
  endtask
  task automatic samp_t(input int x);
    drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 16'(x));
  endtask
  task automatic idle_t();
    drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  typedef struct {
    logic        cv;
    logic [1:0]  c;
    logic        kv;
    logic [15:0] k;
    logic        iv;
    logic [15:0] x;
    logic        ov;
    logic        chk_y;
    logic [15:0] y;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t vc(input int c);
    vec_t r = '{1'b1, 2'(c), 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
    return r;
  endfunction
  function automatic vec_t vk(input int k);
    vec_t r = '{1'b0, 2'd0, 1'b1, 16'(k), 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
    return r;
  endfunction
  function automatic vec_t vx(input int x, input int y);
    vec_t r = '{1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 16'(x), 1'b1, 1'b1, 16'(y)};
    return r;
  endfunction

  int got [$];
  int exp_stall [4] = '{9, 8, 3, 4};

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd = 0; bus.coef_valid = 0;
    bus.coef_in = 0; bus.in_valid = 0; bus.x_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", longint'(bus.y_out), 0);
    chk("rst_ov", longint'(bus.out_valid), 0);
    chk("rst_sat", longint'(bus.sat_flag), 0);
    chk("rst_mode", longint'(bus.mode), 0);
    @(negedge clk);
    rst = 1'b0;

    // impulse, aborted load, bypass, fresh run
    tbl.push_back(vc(1));
    for (int i = 1; i <= 4; i++) tbl.push_back(vk(i));
    tbl.push_back(vc(2));
    tbl.push_back(vx(1, 1)); tbl.push_back(vx(0, 2));
    tbl.push_back(vx(0, 3)); tbl.push_back(vx(0, 4));
    tbl.push_back(vx(0, 0));
    tbl.push_back(vc(1));
    tbl.push_back(vk(9)); tbl.push_back(vk(8));
    tbl.push_back(vc(2));
    tbl.push_back(vx(1, 9)); tbl.push_back(vx(0, 8));
    tbl.push_back(vx(0, 3)); tbl.push_back(vx(0, 4));
    tbl.push_back(vx(0, 0));
    tbl.push_back(vc(3));
    tbl.push_back(vx(-5, -5)); tbl.push_back(vx(7, 7));
    tbl.push_back(vc(2));
    tbl.push_back(vx(1, 9)); tbl.push_back(vx(0, 8));
    tbl.push_back(vx(0, 3)); tbl.push_back(vx(0, 4));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cv, tbl[i].c, tbl[i].kv, tbl[i].k, tbl[i].iv, tbl[i].x);
      chk($sformatf("tbl%0d_ov", i), longint'(bus.out_valid), longint'(tbl[i].ov));
      if (tbl[i].chk_y)
        chk($sformatf("tbl%0d_y", i), longint'($signed(bus.y_out)),
            longint'($signed(tbl[i].y)));
    end

    // stalls between samples
    cmd_t(2'd2);
    samp_t(1); if (bus.out_valid) got.push_back(int'($signed(bus.y_out)));
    idle_t();
    samp_t(0); if (bus.out_valid) got.push_back(int'($signed(bus.y_out)));
    repeat (3) idle_t();
    samp_t(0); if (bus.out_valid) got.push_back(int'($signed(bus.y_out)));
    repeat (2) idle_t();
    samp_t(0); if (bus.out_valid) got.push_back(int'($signed(bus.y_out)));
    chk("stall_cnt", longint'(got.size()), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("stall_y%0d", i), longint'(got[i]), longint'(exp_stall[i]));

    // saturation and its clear on RUN entry
    cmd_t(2'd1);
    repeat (4) coef_t(32767);
    cmd_t(2'd2);
    repeat (3) begin
      samp_t(32767);
      chk("sat_y", longint'($signed(bus.y_out)), 32767);
    end
    chk("sat_flag", longint'(bus.sat_flag), 1);
    cmd_t(2'd2);
    chk("sat_clr", longint'(bus.sat_flag), 0);
    samp_t(32767);

    // asynchronous reset mid-run
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_y", longint'(bus.y_out), 0);
    chk("arst_ov", longint'(bus.out_valid), 0);
    chk("arst_sat", longint'(bus.sat_flag), 0);
    chk("arst_mode", longint'(bus.mode), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cmd_t(2'd2);
    samp_t(1234);
    chk("post_rst_y", longint'($signed(bus.y_out)), 0);
    samp_t(-77);
    chk("post_rst_y2", longint'($signed(bus.y_out)), 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic cv, kv, iv;
      logic [1:0] c;
      int k, x;
      cv = ($urandom_range(0, 24) == 0);
      c  = 2'($urandom_range(0, 3));
      kv = 1'($urandom_range(0, 1));
      iv = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) k = int'($urandom_range(0, 65535)) - 32768;
      else k = int'($urandom_range(0, 511)) - 256;
      if ($urandom_range(0, 7) == 0) x = int'($urandom_range(0, 65535)) - 32768;
      else x = int'($urandom_range(0, 255)) - 128;
      drive(cv, c, kv, 16'(k), iv, 16'(x));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
